// File: rtl/axil_arbiter_2to1.sv
// axil_arbiter_2to1: shares one AXI-Lite slave port between two requesters.
// Write (AW->W->B) and read (AR->R) paths are arbitrated independently with a
// round-robin pointer. The grant is held for the whole transaction.
module axil_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int STRB_WIDTH = DATA_WIDTH/8+1
) (
  input  logic                  axi_aclk,
  input  logic                  axi_areset,
  // requester 0
  input  logic [ADDR_WIDTH-1:0] s0_axi_awaddr,
  input  logic                  s0_axi_awvalid,
  output logic                  s0_axi_awready,
  input  logic [DATA_WIDTH-1:0] s0_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axi_wstrb,
  input  logic                  s0_axi_wvalid,
  output logic                  s0_axi_wready,
  output logic [RESP_WIDTH-1:0] s0_axi_bresp,
  output logic                  s0_axi_bvalid,
  input  logic                  s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axi_araddr,
  input  logic                  s0_axi_arvalid,
  output logic                  s0_axi_arready,
  output logic [DATA_WIDTH-1:0] s0_axi_rdata,
  output logic [RESP_WIDTH-1:0] s0_axi_rresp,
  output logic                  s0_axi_rvalid,
  input  logic                  s0_axi_rready,
  // requester 1
  input  logic [ADDR_WIDTH-1:0] s1_axi_awaddr,
  input  logic                  s1_axi_awvalid,
  output logic                  s1_axi_awready,
  input  logic [DATA_WIDTH-1:0] s1_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axi_wstrb,
  input  logic                  s1_axi_wvalid,
  output logic                  s1_axi_wready,
  output logic [RESP_WIDTH-1:0] s1_axi_bresp,
  output logic                  s1_axi_bvalid,
  input  logic                  s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axi_araddr,
  input  logic                  s1_axi_arvalid,
  output logic                  s1_axi_arready,
  output logic [DATA_WIDTH-1:0] s1_axi_rdata,
  output logic [RESP_WIDTH-1:0] s1_axi_rresp,
  output logic                  s1_axi_rvalid,
  input  logic                  s1_axi_rready,
  // shared downstream port
  output logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
  output logic                  m0_axi_awvalid,
  input  logic                  m0_axi_awready,
  output logic [DATA_WIDTH-1:0] m0_axi_wdata,
  output logic [STRB_WIDTH-1:0] m0_axi_wstrb,
  output logic                  m0_axi_wvalid,
  input  logic                  m0_axi_wready,
  input  logic [RESP_WIDTH-1:0] m0_axi_bresp,
  input  logic                  m0_axi_bvalid,
  output logic                  m0_axi_bready,
  output logic [ADDR_WIDTH-1:0] m0_axi_araddr,
  output logic                  m0_axi_arvalid,
  input  logic                  m0_axi_arready,
  input  logic [DATA_WIDTH-1:0] m0_axi_rdata,
  input  logic [RESP_WIDTH-1:0] m0_axi_rresp,
  input  logic                  m0_axi_rvalid,
  output logic                  m0_axi_rready,
  // status
  output logic                  wr_grant,
  output logic                  wr_busy,
  output logic                  rd_grant,
  output logic                  rd_busy
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_AW   = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [1:0] r_wstate;
  logic       r_wown;
  logic       r_wlast;
  logic [1:0] r_rstate;
  logic       r_rown;
  logic       r_rlast;

  logic       w_aw_hs;
  logic       w_w_hs;
  logic       w_b_hs;
  logic       w_ar_hs;
  logic       w_r_hs;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  function automatic logic f_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    else if (req1)    return 1'b1;
    else              return 1'b0;
  endfunction

  assign w_aw_hs = m0_axi_awvalid && m0_axi_awready;
  assign w_w_hs  = m0_axi_wvalid  && m0_axi_wready;
  assign w_b_hs  = m0_axi_bvalid  && m0_axi_bready;
  assign w_ar_hs = m0_axi_arvalid && m0_axi_arready;
  assign w_r_hs  = m0_axi_rvalid  && m0_axi_rready;

  assign wr_grant = r_wown;
  assign wr_busy  = (r_wstate != W_IDLE);
  assign rd_grant = r_rown;
  assign rd_busy  = (r_rstate != R_IDLE);

  // Write FSM: arbitrate in idle, then walk AW, W, B for the owner.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wstate <= W_IDLE;
      r_wown   <= 1'b0;
      r_wlast  <= 1'b1;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (s0_axi_awvalid || s1_axi_awvalid) begin
            r_wown   <= f_pick(s0_axi_awvalid, s1_axi_awvalid, r_wlast);
            r_wstate <= W_AW;
          end
        end
        W_AW:   if (w_aw_hs) r_wstate <= W_DATA;
        W_DATA: if (w_w_hs)  r_wstate <= W_RESP;
        W_RESP: begin
          if (w_b_hs) begin
            r_wstate <= W_IDLE;
            r_wlast  <= r_wown;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: arbitrate in idle, then walk AR, R for the owner.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_rstate <= R_IDLE;
      r_rown   <= 1'b0;
      r_rlast  <= 1'b1;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s0_axi_arvalid || s1_axi_arvalid) begin
            r_rown   <= f_pick(s0_axi_arvalid, s1_axi_arvalid, r_rlast);
            r_rstate <= R_AR;
          end
        end
        R_AR: if (w_ar_hs) r_rstate <= R_DATA;
        R_DATA: begin
          if (w_r_hs) begin
            r_rstate <= R_IDLE;
            r_rlast  <= r_rown;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Write-path routing: only the channel of the current state is connected, only to the owner.
  always_comb begin
    m0_axi_awaddr  = '0;
    m0_axi_awvalid = 1'b0;
    m0_axi_wdata   = '0;
    m0_axi_wstrb   = '0;
    m0_axi_wvalid  = 1'b0;
    m0_axi_bready  = 1'b0;
    s0_axi_awready = 1'b0;
    s1_axi_awready = 1'b0;
    s0_axi_wready  = 1'b0;
    s1_axi_wready  = 1'b0;
    s0_axi_bresp   = '0;
    s1_axi_bresp   = '0;
    s0_axi_bvalid  = 1'b0;
    s1_axi_bvalid  = 1'b0;
    case (r_wstate)
      W_AW: begin
        m0_axi_awaddr  = r_wown ? s1_axi_awaddr  : s0_axi_awaddr;
        m0_axi_awvalid = r_wown ? s1_axi_awvalid : s0_axi_awvalid;
        if (r_wown) s1_axi_awready = m0_axi_awready;
        else        s0_axi_awready = m0_axi_awready;
      end
      W_DATA: begin
        m0_axi_wdata  = r_wown ? s1_axi_wdata  : s0_axi_wdata;
        m0_axi_wstrb  = r_wown ? s1_axi_wstrb  : s0_axi_wstrb;
        m0_axi_wvalid = r_wown ? s1_axi_wvalid : s0_axi_wvalid;
        if (r_wown) s1_axi_wready = m0_axi_wready;
        else        s0_axi_wready = m0_axi_wready;
      end
      W_RESP: begin
        m0_axi_bready = r_wown ? s1_axi_bready : s0_axi_bready;
        if (r_wown) begin
          s1_axi_bresp  = m0_axi_bresp;
          s1_axi_bvalid = m0_axi_bvalid;
        end else begin
          s0_axi_bresp  = m0_axi_bresp;
          s0_axi_bvalid = m0_axi_bvalid;
        end
      end
      default: ;
    endcase
  end

  // Read-path routing: same scheme as the write path for AR and R.
  always_comb begin
    m0_axi_araddr  = '0;
    m0_axi_arvalid = 1'b0;
    m0_axi_rready  = 1'b0;
    s0_axi_arready = 1'b0;
    s1_axi_arready = 1'b0;
    s0_axi_rdata   = '0;
    s1_axi_rdata   = '0;
    s0_axi_rresp   = '0;
    s1_axi_rresp   = '0;
    s0_axi_rvalid  = 1'b0;
    s1_axi_rvalid  = 1'b0;
    case (r_rstate)
      R_AR: begin
        m0_axi_araddr  = r_rown ? s1_axi_araddr  : s0_axi_araddr;
        m0_axi_arvalid = r_rown ? s1_axi_arvalid : s0_axi_arvalid;
        if (r_rown) s1_axi_arready = m0_axi_arready;
        else        s0_axi_arready = m0_axi_arready;
      end
      R_DATA: begin
        m0_axi_rready = r_rown ? s1_axi_rready : s0_axi_rready;
        if (r_rown) begin
          s1_axi_rdata  = m0_axi_rdata;
          s1_axi_rresp  = m0_axi_rresp;
          s1_axi_rvalid = m0_axi_rvalid;
        end else begin
          s0_axi_rdata  = m0_axi_rdata;
          s0_axi_rresp  = m0_axi_rresp;
          s0_axi_rvalid = m0_axi_rvalid;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Directed bench for axil_arbiter_2to1 with a small reactive downstream slave model.
module tb_axil_arbiter_2to1;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int RW = 3;
  localparam int SW = DW/8+1;
  localparam int LIM = 200;

  // monitor counter indices
  localparam int C_AW = 0, C_W = 1, C_AR = 2, C_B0 = 3, C_B1 = 4, C_R0 = 5, C_R1 = 6;
  localparam int C_WEARLY = 7, C_LEAK = 8, C_BUSY = 9, C_BOTH = 10, C_STAB = 11, C_BVR0 = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [AW-1:0] s_awaddr [2];
  logic [DW-1:0] s_wdata  [2];
  logic [SW-1:0] s_wstrb  [2];
  logic [AW-1:0] s_araddr [2];
  logic [1:0]    s_awvalid = '0, s_wvalid = '0, s_bready = '0, s_arvalid = '0, s_rready = '0;

  logic          s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
  logic          s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
  logic [RW-1:0] s0_bresp, s0_rresp, s1_bresp, s1_rresp;
  logic [DW-1:0] s0_rdata, s1_rdata;

  logic [AW-1:0] m0_awaddr, m0_araddr;
  logic          m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [SW-1:0] m0_wstrb;
  logic [RW-1:0] m0_bresp, m0_rresp;
  logic          wr_grant, wr_busy, rd_grant, rd_busy;

  axil_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .STRB_WIDTH(SW)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s0_awready),
    .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wvalid(s_wvalid[0]),
    .s0_axi_wready(s0_wready), .s0_axi_bresp(s0_bresp), .s0_axi_bvalid(s0_bvalid),
    .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arvalid(s_arvalid[0]),
    .s0_axi_arready(s0_arready), .s0_axi_rdata(s0_rdata), .s0_axi_rresp(s0_rresp),
    .s0_axi_rvalid(s0_rvalid), .s0_axi_rready(s_rready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s1_awready),
    .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wvalid(s_wvalid[1]),
    .s1_axi_wready(s1_wready), .s1_axi_bresp(s1_bresp), .s1_axi_bvalid(s1_bvalid),
    .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arvalid(s_arvalid[1]),
    .s1_axi_arready(s1_arready), .s1_axi_rdata(s1_rdata), .s1_axi_rresp(s1_rresp),
    .s1_axi_rvalid(s1_rvalid), .s1_axi_rready(s_rready[1]),
    .m0_axi_awaddr(m0_awaddr), .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready),
    .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb), .m0_axi_wvalid(m0_wvalid),
    .m0_axi_wready(m0_wready), .m0_axi_bresp(m0_bresp), .m0_axi_bvalid(m0_bvalid),
    .m0_axi_bready(m0_bready), .m0_axi_araddr(m0_araddr), .m0_axi_arvalid(m0_arvalid),
    .m0_axi_arready(m0_arready), .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp),
    .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready),
    .wr_grant(wr_grant), .wr_busy(wr_busy), .rd_grant(rd_grant), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  // downstream slave model: ready after a programmable stall, response one cycle after the data beat
  int            aw_stall = 0, w_stall = 0, aw_wait, w_wait;
  logic          b_pend, r_pend;
  logic [RW-1:0] mdl_bresp = 3'b010;
  logic [RW-1:0] mdl_rresp = 3'b001;
  logic [DW-1:0] mdl_rdata = 32'h1234_5678;

  assign m0_awready = m0_awvalid && (aw_wait >= aw_stall);
  assign m0_wready  = m0_wvalid && (w_wait >= w_stall);
  assign m0_arready = m0_arvalid;
  assign m0_bresp   = m0_bvalid ? mdl_bresp : '0;
  assign m0_rdata   = m0_rvalid ? mdl_rdata : '0;
  assign m0_rresp   = m0_rvalid ? mdl_rresp : '0;

  // slave model state
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; b_pend <= 1'b0; r_pend <= 1'b0;
      m0_bvalid <= 1'b0; m0_rvalid <= 1'b0;
    end else begin
      if (m0_awvalid && m0_awready) aw_wait <= 0; else if (m0_awvalid) aw_wait <= aw_wait + 1;
      if (m0_wvalid && m0_wready)   w_wait <= 0;  else if (m0_wvalid)  w_wait <= w_wait + 1;
      if (m0_wvalid && m0_wready) b_pend <= 1'b1;
      if (b_pend) begin m0_bvalid <= 1'b1; b_pend <= 1'b0; end
      else if (m0_bvalid && m0_bready) m0_bvalid <= 1'b0;
      if (m0_arvalid && m0_arready) r_pend <= 1'b1;
      if (r_pend) begin m0_rvalid <= 1'b1; r_pend <= 1'b0; end
      else if (m0_rvalid && m0_rready) m0_rvalid <= 1'b0;
    end
  end

  // monitor: counts handshakes and protocol/routing violations, records grant order
  int            cnt [13];
  int            wr_q[$];
  int            rd_q[$];
  logic [AW-1:0] last_awaddr, last_araddr, p_awaddr;
  logic [DW-1:0] last_wdata, p_wdata;
  logic [SW-1:0] last_wstrb, p_wstrb;
  logic [RW-1:0] p_bresp;
  logic          aw_done = 1'b0, p_wbusy = 1'b0, p_rbusy = 1'b0;
  logic          p_awst = 1'b0, p_wst = 1'b0, p_bst = 1'b0, p_bv0 = 1'b0;
  initial for (int i = 0; i < 13; i++) cnt[i] = 0;

  // sampled on the falling edge, when every input and output is settled
  always @(negedge clk) begin
    if (rst) begin
      aw_done = 1'b0; p_wbusy = 1'b0; p_rbusy = 1'b0;
      p_awst = 1'b0; p_wst = 1'b0; p_bst = 1'b0; p_bv0 = 1'b0;
    end else begin
      if (m0_wvalid && !aw_done) cnt[C_WEARLY]++;
      if (m0_awvalid && m0_awready) begin cnt[C_AW]++; last_awaddr = m0_awaddr; aw_done = 1'b1; end
      if (m0_wvalid && m0_wready) begin
        cnt[C_W]++; last_wdata = m0_wdata; last_wstrb = m0_wstrb; aw_done = 1'b0;
      end
      if (m0_arvalid && m0_arready) begin cnt[C_AR]++; last_araddr = m0_araddr; end
      if (s0_bvalid && s_bready[0]) cnt[C_B0]++;
      if (s1_bvalid && s_bready[1]) cnt[C_B1]++;
      if (s0_rvalid && s_rready[0]) cnt[C_R0]++;
      if (s1_rvalid && s_rready[1]) cnt[C_R1]++;
      if (wr_busy) cnt[C_BUSY]++;
      if (wr_busy && rd_busy) cnt[C_BOTH]++;
      if (wr_busy && !p_wbusy) wr_q.push_back(int'(wr_grant));
      if (rd_busy && !p_rbusy) rd_q.push_back(int'(rd_grant));
      if (!wr_busy && (s0_awready || s0_wready || s0_bvalid || s1_awready || s1_wready || s1_bvalid))
        cnt[C_LEAK]++;
      if (wr_busy && !wr_grant && (s1_awready || s1_wready || s1_bvalid || s1_bresp != '0)) cnt[C_LEAK]++;
      if (wr_busy && wr_grant && (s0_awready || s0_wready || s0_bvalid || s0_bresp != '0)) cnt[C_LEAK]++;
      if (rd_busy && !rd_grant && (s1_arready || s1_rvalid || s1_rdata != '0)) cnt[C_LEAK]++;
      if (rd_busy && rd_grant && (s0_arready || s0_rvalid || s0_rdata != '0)) cnt[C_LEAK]++;
      if (p_awst && (!m0_awvalid || m0_awaddr != p_awaddr)) cnt[C_STAB]++;
      if (p_wst && (!m0_wvalid || m0_wdata != p_wdata || m0_wstrb != p_wstrb)) cnt[C_STAB]++;
      if (p_bst && (!s0_bvalid || s0_bresp != p_bresp)) cnt[C_STAB]++;
      if (s0_bvalid && !p_bv0) cnt[C_BVR0]++;
      p_awst = m0_awvalid && !m0_awready; p_awaddr = m0_awaddr;
      p_wst  = m0_wvalid && !m0_wready;   p_wdata = m0_wdata; p_wstrb = m0_wstrb;
      p_bst  = s0_bvalid && !s_bready[0]; p_bresp = s0_bresp;
      p_bv0  = s0_bvalid; p_wbusy = wr_busy; p_rbusy = rd_busy;
    end
  end

  function automatic logic aw_rdy(input int n); return (n == 1) ? s1_awready : s0_awready; endfunction
  function automatic logic w_rdy(input int n);  return (n == 1) ? s1_wready  : s0_wready;  endfunction
  function automatic logic b_vld(input int n);  return (n == 1) ? s1_bvalid  : s0_bvalid;  endfunction
  function automatic logic ar_rdy(input int n); return (n == 1) ? s1_arready : s0_arready; endfunction
  function automatic logic r_vld(input int n);  return (n == 1) ? s1_rvalid  : s0_rvalid;  endfunction

  // requester-side write transaction; AW and W offered together, B accepted after bstall cycles
  task automatic write_txn(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, input int bstall,
                           output logic [RW-1:0] resp, output logic ok);
    int k;
    ok = 1'b1;
    s_awaddr[n] = a; s_awvalid[n] = 1'b1;
    s_wdata[n] = d; s_wstrb[n] = s; s_wvalid[n] = 1'b1;
    s_bready[n] = (bstall == 0);
    #1;
    k = 0; while (!aw_rdy(n) && k < LIM) begin @(posedge clk); #1; k++; end
    if (!aw_rdy(n)) ok = 1'b0;
    @(posedge clk); #1; s_awvalid[n] = 1'b0;
    k = 0; while (!w_rdy(n) && k < LIM) begin @(posedge clk); #1; k++; end
    if (!w_rdy(n)) ok = 1'b0;
    @(posedge clk); #1; s_wvalid[n] = 1'b0;
    k = 0; while (!b_vld(n) && k < LIM) begin @(posedge clk); #1; k++; end
    if (!b_vld(n)) ok = 1'b0;
    if (bstall > 0) begin
      repeat (bstall) begin @(posedge clk); #1; end
      s_bready[n] = 1'b1;
    end
    resp = (n == 1) ? s1_bresp : s0_bresp;
    @(posedge clk); #1; s_bready[n] = 1'b0;
  endtask

  // requester-side read transaction
  task automatic read_txn(input int n, input logic [AW-1:0] a,
                          output logic [DW-1:0] data, output logic [RW-1:0] resp, output logic ok);
    int k;
    ok = 1'b1;
    s_araddr[n] = a; s_arvalid[n] = 1'b1; s_rready[n] = 1'b1;
    #1;
    k = 0; while (!ar_rdy(n) && k < LIM) begin @(posedge clk); #1; k++; end
    if (!ar_rdy(n)) ok = 1'b0;
    @(posedge clk); #1; s_arvalid[n] = 1'b0;
    k = 0; while (!r_vld(n) && k < LIM) begin @(posedge clk); #1; k++; end
    if (!r_vld(n)) ok = 1'b0;
    data = (n == 1) ? s1_rdata : s0_rdata;
    resp = (n == 1) ? s1_rresp : s0_rresp;
    @(posedge clk); #1; s_rready[n] = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] v;
    rst = 1'b1; s_awvalid = 2'b01; s_arvalid = 2'b10;
    s_awaddr[0] = 8'h00; s_araddr[1] = 8'h00; s_wstrb[0] = '0; s_wstrb[1] = '0;
    s_awaddr[1] = 8'h00; s_araddr[0] = 8'h00; s_wdata[0] = '0; s_wdata[1] = '0;
    repeat (3) @(posedge clk); #1;
    v = {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready, s0_awready, s0_wready,
         s0_bvalid, s1_awready, s1_wready, s1_bvalid, s0_arready, s0_rvalid, s1_arready, s1_rvalid};
    n_cmp++; if (v !== 15'd0) begin n_fail++; $display("FAIL reset_valids: got %b expected 0", v); end
    n_cmp++; if ({wr_busy, rd_busy} !== 2'b00) begin n_fail++; $display("FAIL reset_busy: got %b expected 00", {wr_busy, rd_busy}); end
    n_cmp++; if ({wr_grant, rd_grant} !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b expected 00", {wr_grant, rd_grant}); end
    n_cmp++; if ({m0_awaddr, s1_rdata, s0_bresp} !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {m0_awaddr, s1_rdata, s0_bresp}); end
    s_awvalid = '0; s_arvalid = '0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int base[13]; int qb; logic [RW-1:0] resp; logic ok;
    base = cnt; qb = wr_q.size();
    write_txn(0, 8'h04, 32'hDEAD_BEEF, 5'h0F, 0, resp, ok);
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t1_timeout: got %b expected 1", ok); end
    n_cmp++; if (cnt[C_AW] - base[C_AW] !== 1) begin n_fail++; $display("FAIL t1_aw_count: got %0d expected 1", cnt[C_AW] - base[C_AW]); end
    n_cmp++; if (last_awaddr !== 8'h04) begin n_fail++; $display("FAIL t1_awaddr: got %h expected 04", last_awaddr); end
    n_cmp++; if (cnt[C_W] - base[C_W] !== 1) begin n_fail++; $display("FAIL t1_w_count: got %0d expected 1", cnt[C_W] - base[C_W]); end
    n_cmp++; if ({last_wdata, last_wstrb} !== {32'hDEAD_BEEF, 5'h0F}) begin n_fail++; $display("FAIL t1_wdata: got %h/%h expected deadbeef/0f", last_wdata, last_wstrb); end
    n_cmp++; if (resp !== 3'b010) begin n_fail++; $display("FAIL t1_bresp: got %b expected 010", resp); end
    n_cmp++; if (cnt[C_B0] - base[C_B0] !== 1) begin n_fail++; $display("FAIL t1_b_count: got %0d expected 1", cnt[C_B0] - base[C_B0]); end
    n_cmp++; if (cnt[C_BUSY] - base[C_BUSY] !== 4) begin n_fail++; $display("FAIL t1_busy_cycles: got %0d expected 4", cnt[C_BUSY] - base[C_BUSY]); end
    n_cmp++; if (cnt[C_WEARLY] - base[C_WEARLY] !== 0) begin n_fail++; $display("FAIL t1_w_before_aw: got %0d expected 0", cnt[C_WEARLY] - base[C_WEARLY]); end
    n_cmp++; if (cnt[C_LEAK] - base[C_LEAK] !== 0) begin n_fail++; $display("FAIL t1_nonowner: got %0d expected 0", cnt[C_LEAK] - base[C_LEAK]); end
    n_cmp++; if (wr_q.size() - qb !== 1 || wr_q[qb] !== 0) begin n_fail++; $display("FAIL t1_grant: got %0d entries expected 1 of owner 0", wr_q.size() - qb); end
  endtask

  task automatic test_round_robin();
    int base[13]; int qb; logic [RW-1:0] r0, r1; logic ok0, ok1; logic all_ok;
    apply_reset();
    base = cnt; qb = wr_q.size(); all_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fork
        write_txn(0, 8'h20 + 8'(i), 32'hA000_0000 + i, 5'h1F, 0, r0, ok0);
        write_txn(1, 8'h40 + 8'(i), 32'hB000_0000 + i, 5'h03, 0, r1, ok1);
      join
      all_ok = all_ok & ok0 & ok1;
    end
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL t2_timeout: got %b expected 1", all_ok); end
    n_cmp++; if (wr_q.size() - qb !== 8) begin n_fail++; $display("FAIL t2_grant_count: got %0d expected 8", wr_q.size() - qb); end
    for (int i = 0; i < 8 && qb + i < wr_q.size(); i++) begin
      n_cmp++; if (wr_q[qb + i] !== (i % 2)) begin n_fail++; $display("FAIL t2_grant_order[%0d]: got %0d expected %0d", i, wr_q[qb + i], i % 2); end
    end
    n_cmp++; if ({cnt[C_B0] - base[C_B0], cnt[C_B1] - base[C_B1]} !== {32'd4, 32'd4}) begin n_fail++; $display("FAIL t2_b_counts: got %0d/%0d expected 4/4", cnt[C_B0] - base[C_B0], cnt[C_B1] - base[C_B1]); end
    n_cmp++; if (cnt[C_LEAK] - base[C_LEAK] !== 0) begin n_fail++; $display("FAIL t2_nonowner: got %0d expected 0", cnt[C_LEAK] - base[C_LEAK]); end
  endtask

  task automatic test_concurrent_rw();
    int base[13]; int wb, rb; logic [RW-1:0] bresp, rresp; logic [DW-1:0] rdata; logic okw, okr;
    base = cnt; wb = wr_q.size(); rb = rd_q.size();
    fork
      write_txn(0, 8'h10, 32'hCAFE_0001, 5'h1F, 0, bresp, okw);
      read_txn(1, 8'h18, rdata, rresp, okr);
    join
    repeat (2) @(posedge clk); #1;
    n_cmp++; if ({okw, okr} !== 2'b11) begin n_fail++; $display("FAIL t3_timeout: got %b expected 11", {okw, okr}); end
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL t3_rdata: got %h expected 12345678", rdata); end
    n_cmp++; if (rresp !== 3'b001) begin n_fail++; $display("FAIL t3_rresp: got %b expected 001", rresp); end
    n_cmp++; if ({last_araddr, last_awaddr} !== {8'h18, 8'h10}) begin n_fail++; $display("FAIL t3_addrs: got %h/%h expected 18/10", last_araddr, last_awaddr); end
    n_cmp++; if (cnt[C_BOTH] - base[C_BOTH] < 1) begin n_fail++; $display("FAIL t3_overlap: got %0d expected >=1", cnt[C_BOTH] - base[C_BOTH]); end
    n_cmp++; if (rd_q.size() - rb !== 1 || rd_q[rb] !== 1) begin n_fail++; $display("FAIL t3_rd_grant: got %0d entries expected 1 of owner 1", rd_q.size() - rb); end
    n_cmp++; if (wr_q.size() - wb !== 1 || wr_q[wb] !== 0) begin n_fail++; $display("FAIL t3_wr_grant: got %0d entries expected 1 of owner 0", wr_q.size() - wb); end
    n_cmp++; if ({cnt[C_R0] - base[C_R0], cnt[C_B1] - base[C_B1]} !== 64'd0) begin n_fail++; $display("FAIL t3_cross_route: got r0=%0d b1=%0d expected 0/0", cnt[C_R0] - base[C_R0], cnt[C_B1] - base[C_B1]); end
    n_cmp++; if (cnt[C_R1] - base[C_R1] !== 1) begin n_fail++; $display("FAIL t3_r1_count: got %0d expected 1", cnt[C_R1] - base[C_R1]); end
    n_cmp++; if (cnt[C_LEAK] - base[C_LEAK] !== 0) begin n_fail++; $display("FAIL t3_nonowner: got %0d expected 0", cnt[C_LEAK] - base[C_LEAK]); end
  endtask

  task automatic test_stalls();
    int base[13]; logic [RW-1:0] resp; logic ok;
    base = cnt;
    aw_stall = 3; w_stall = 3;
    write_txn(0, 8'h2C, 32'hA5A5_5A5A, 5'h11, 3, resp, ok);
    aw_stall = 0; w_stall = 0;
    repeat (2) @(posedge clk); #1;
    n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL t4_timeout: got %b expected 1", ok); end
    n_cmp++; if ({cnt[C_AW] - base[C_AW], cnt[C_W] - base[C_W]} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL t4_hs_counts: got aw=%0d w=%0d expected 1/1", cnt[C_AW] - base[C_AW], cnt[C_W] - base[C_W]); end
    n_cmp++; if (cnt[C_B0] - base[C_B0] !== 1) begin n_fail++; $display("FAIL t4_b_count: got %0d expected 1", cnt[C_B0] - base[C_B0]); end
    n_cmp++; if (cnt[C_BVR0] - base[C_BVR0] !== 1) begin n_fail++; $display("FAIL t4_bvalid_pulses: got %0d expected 1", cnt[C_BVR0] - base[C_BVR0]); end
    n_cmp++; if (cnt[C_STAB] - base[C_STAB] !== 0) begin n_fail++; $display("FAIL t4_stability: got %0d expected 0", cnt[C_STAB] - base[C_STAB]); end
    n_cmp++; if (cnt[C_BUSY] - base[C_BUSY] !== 13) begin n_fail++; $display("FAIL t4_busy_cycles: got %0d expected 13", cnt[C_BUSY] - base[C_BUSY]); end
    n_cmp++; if ({last_awaddr, last_wdata, resp} !== {8'h2C, 32'hA5A5_5A5A, 3'b010}) begin n_fail++; $display("FAIL t4_payload: got %h/%h/%b expected 2c/a5a55a5a/010", last_awaddr, last_wdata, resp); end
  endtask

  task automatic test_reset_mid_write();
    logic [14:0] v; int k;
    w_stall = 50;
    s_awaddr[0] = 8'h30; s_wdata[0] = 32'h0BAD_F00D; s_wstrb[0] = 5'h0F;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_bready[0] = 1'b1;
    #1;
    k = 0; while (!m0_wvalid && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++; if (m0_wvalid !== 1'b1) begin n_fail++; $display("FAIL t5_reach_wdata: got %b expected 1", m0_wvalid); end
    s_awaddr[1] = 8'h34; s_wdata[1] = 32'h1111_2222; s_wstrb[1] = 5'h01;
    s_awvalid[1] = 1'b1; s_wvalid[1] = 1'b1;
    #2 rst = 1'b1;
    #1;
    v = {m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready, s0_awready, s0_wready,
         s0_bvalid, s1_awready, s1_wready, s1_bvalid, s0_arready, s0_rvalid, s1_arready, s1_rvalid};
    n_cmp++; if (v !== 15'd0) begin n_fail++; $display("FAIL t5_async_valids: got %b expected 0", v); end
    n_cmp++; if ({wr_busy, wr_grant, m0_wdata} !== '0) begin n_fail++; $display("FAIL t5_async_busy: got busy=%b grant=%b wdata=%h expected 0", wr_busy, wr_grant, m0_wdata); end
    @(posedge clk); #1;
    w_stall = 0; rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if ({wr_busy, wr_grant} !== 2'b10) begin n_fail++; $display("FAIL t5_regrant: got busy=%b grant=%b expected 1/0", wr_busy, wr_grant); end
    n_cmp++; if (m0_awaddr !== 8'h30) begin n_fail++; $display("FAIL t5_regrant_addr: got %h expected 30", m0_awaddr); end
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_concurrent_rw();
    test_stalls();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
